echo_request_decoder: RTL and testbench
=======================================

Name: echo_request_decoder

Overview:
Host-to-hardware end of the echo portal; the request-side counterpart of the indication path that delivers echo results. Accepts a serialized word stream from the host portal FIFO, parses a header, collects argument words, and invokes the Echo request methods say(v) / say2(a,b) through guarded ENA/RDY handshakes. Malformed messages are discarded and counted.

Parameters:
DATA_WIDTH, 32, width of stream words and of each method argument.
ERR_CNT_WIDTH, 8, width of the saturating error counter.

Ports:
CLK  input  1  clock; all state updates on posedge.
nRST  input  1  reset, asynchronous, active-low.
in_enq__ENA  input  1  host pushes a word; asserted only while in_enq__RDY=1.
in_enq_v  input  DATA_WIDTH  stream word.
in_enq__RDY  output  1  decoder can accept a word this cycle.
say__ENA  output  1  invoke say(v).
say_v  output  DATA_WIDTH  say argument.
say__RDY  input  1  say method is ready.
say2__ENA  output  1  invoke say2(a,b).
say2_a  output  DATA_WIDTH  first say2 argument.
say2_b  output  DATA_WIDTH  second say2 argument.
say2__RDY  input  1  say2 method is ready.
err_pulse  output  1  one-cycle pulse when a message is rejected.
err_count  output  ERR_CNT_WIDTH  saturating count of rejected messages.

Behaviour:
- Reset: nRST low clears asynchronously; state=HDR, word count=0, argument registers=0, err_count=0; all outputs 0 except in_enq__RDY=1 after reset deasserts. Any partial message is lost.
- Header word: [31:16]=method id, [15:0]=payload word count. Valid pairs: id 0 with len 1 (say); id 1 with len 2 (say2).
- States: HDR, ARG, ISSUE, DROP. A word is accepted on a cycle where in_enq__ENA=1 and in_enq__RDY=1.
- in_enq__RDY=1 in HDR, ARG and DROP; 0 in ISSUE.
- HDR, valid header: latch the id, remaining=len, go to ARG.
- HDR, invalid header (unknown id, or len not matching the id, including len 0):
  - err_pulse=1 next cycle; err_count += 1, saturating at all-ones.
  - If len=0, stay in HDR; otherwise remaining=len and go to DROP.
- ARG: each accepted word is stored in arg slot (len-remaining) and remaining is decremented; the word that brings remaining to 0 moves to ISSUE.
- DROP: accepted words are discarded and remaining is decremented; remaining reaching 0 returns to HDR.
- ISSUE:
  - say__ENA = (id==0) & say__RDY; say2__ENA = (id==1) & say2__RDY. Combinational from registered state.
  - Argument outputs are driven from registers and held stable throughout ISSUE.
  - On the cycle ENA is asserted, return to HDR.
  - Minimum latency: ENA in the cycle after the last argument word is accepted.
  - If RDY is low, wait indefinitely while back-pressuring the input.
- say__ENA and say2__ENA are never asserted together and never outside ISSUE.
- Throughput: at most one message per (1+len+1) cycles.

Optional Feature:
ECHO_DECODE_TRACE_EN:
- Defined: simulation-only $display on each method invocation (the say value; the say2 a and b values) and on each rejected header (id, len).
- Undefined: no trace code is compiled; RTL behaviour is identical.

Decomposition:
- Package echo_pkg holds:
  - method id constants ECHO_SAY=0, ECHO_SAY2=1;
  - expected lengths 1 and 2;
  - header field positions/widths;
  - the state enum {HDR, ARG, ISSUE, DROP}.
- One sub-module: echo_arg_collector, which owns the remaining-word counter and the two argument registers and signals last-word; the FSM stays in echo_request_decoder.

Test Plan:
- Push 0x00000001 then 22, with say__RDY=1 -> say__ENA for exactly 1 cycle with say_v=22, one cycle after word 22 is accepted; err_count=0.
- Push 0x00010002, 5, 7 -> say2__ENA for 1 cycle with say2_a=5, say2_b=7; say__ENA stays 0.
- Push a say message with 22 while say__RDY is held low for 3 cycles -> say__ENA=0 and in_enq__RDY=0 during those cycles; ENA fires in the first cycle say__RDY=1; the next header is accepted the following cycle.
- Push 0x00070003, 1, 2, 3, then 0x00000001, 9 -> err_pulse once, err_count=1, the 3 words are dropped, then say_v=9 is issued.
- Push 0x00000000 (len 0) 256 times -> err_count saturates at 255; no ENA is ever asserted; the decoder stays in HDR.
- Push 0x00010002 and 5, then pulse nRST low -> all outputs 0 at once; after release, push 0x00000001, 4 -> say_v=4, with no stale say2 issued.

Source files
------------

// File: rtl/echo_pkg.sv
// Shared definitions for the echo request decoder: method ids, expected argument
// counts, header field layout and the decoder state encoding.
package echo_pkg;

    localparam logic [15:0] ECHO_SAY      = 16'd0;
    localparam logic [15:0] ECHO_SAY2     = 16'd1;
    localparam logic [15:0] ECHO_SAY_LEN  = 16'd1;
    localparam logic [15:0] ECHO_SAY2_LEN = 16'd2;

    localparam int HDR_ID_LSB  = 16;
    localparam int HDR_ID_W    = 16;
    localparam int HDR_LEN_LSB = 0;
    localparam int HDR_LEN_W   = 16;

    typedef enum logic [1:0] {HDR, ARG, ISSUE, DROP} state_t;

    // A header is usable only when its length matches the method it names.
    function automatic logic hdr_valid(input logic [HDR_ID_W-1:0] id,
                                       input logic [HDR_LEN_W-1:0] len);
        return ((id == ECHO_SAY)  && (len == ECHO_SAY_LEN)) ||
               ((id == ECHO_SAY2) && (len == ECHO_SAY2_LEN));
    endfunction

endpackage

// File: rtl/echo_request_decoder_if.sv
// Host word stream in, say/say2 method invocations out, plus reject reporting.
interface echo_request_decoder_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ERR_CNT_WIDTH = 8
);
    logic                     in_enq__ENA;
    logic [DATA_WIDTH-1:0]    in_enq_v;
    logic                     in_enq__RDY;
    logic                     say__ENA;
    logic [DATA_WIDTH-1:0]    say_v;
    logic                     say__RDY;
    logic                     say2__ENA;
    logic [DATA_WIDTH-1:0]    say2_a;
    logic [DATA_WIDTH-1:0]    say2_b;
    logic                     say2__RDY;
    logic                     err_pulse;
    logic [ERR_CNT_WIDTH-1:0] err_count;

    modport master (
        output in_enq__ENA, in_enq_v, say__RDY, say2__RDY,
        input  in_enq__RDY, say__ENA, say_v, say2__ENA, say2_a, say2_b,
               err_pulse, err_count
    );

    modport slave (
        input  in_enq__ENA, in_enq_v, say__RDY, say2__RDY,
        output in_enq__RDY, say__ENA, say_v, say2__ENA, say2_a, say2_b,
               err_pulse, err_count
    );
endinterface

// File: rtl/echo_arg_collector.sv
// Remaining-word counter and argument slots for one message.
// Latency: slot written on the accepting edge; last is combinational from the counter.
module echo_arg_collector #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  load,
    input  logic [CNT_WIDTH-1:0]  load_len,
    input  logic                  step,
    input  logic                  store,
    input  logic [DATA_WIDTH-1:0] word,
    output logic                  last,
    output logic [DATA_WIDTH-1:0] arg_a,
    output logic [DATA_WIDTH-1:0] arg_b
);

    logic [CNT_WIDTH-1:0] remaining_q;
    logic [CNT_WIDTH-1:0] len_q;
    logic [CNT_WIDTH-1:0] slot;

    assign slot = len_q - remaining_q;
    assign last = (remaining_q == CNT_WIDTH'(1));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            remaining_q <= '0;
            len_q       <= '0;
            arg_a       <= '0;
            arg_b       <= '0;
        end else if (load) begin
            remaining_q <= load_len;
            len_q       <= load_len;
        end else if (step) begin
            remaining_q <= remaining_q - CNT_WIDTH'(1);
            if (store) begin
                if (slot == CNT_WIDTH'(0))      arg_a <= word;
                else if (slot == CNT_WIDTH'(1)) arg_b <= word;
            end
        end
    end

endmodule

// File: rtl/echo_request_decoder.sv
// Parses host words into say/say2 calls; rejects bad headers. Optional trace: ECHO_DECODE_TRACE_EN.
// Latency: method ENA the cycle after the last argument word is accepted.
// Backpressure: in_enq__RDY drops while a call waits on its method RDY.
module echo_request_decoder
    import echo_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ERR_CNT_WIDTH = 8
) (
    input logic                 CLK,
    input logic                 nRST,
    echo_request_decoder_if.slave bus
);

    state_t                   state_q, state_d;
    logic                     is_say2_q;
    logic                     err_pulse_q;
    logic [ERR_CNT_WIDTH-1:0] err_count_q;
    logic                     acc, hdr_ok, last;
    logic                     load, step, store, err_set;
    logic                     say_ena, say2_ena;
    logic [HDR_ID_W-1:0]      hdr_id;
    logic [HDR_LEN_W-1:0]     hdr_len;
    logic [DATA_WIDTH-1:0]    arg_a, arg_b;

    assign hdr_id  = bus.in_enq_v[HDR_ID_LSB +: HDR_ID_W];
    assign hdr_len = bus.in_enq_v[HDR_LEN_LSB +: HDR_LEN_W];
    assign hdr_ok  = hdr_valid(hdr_id, hdr_len);
    assign acc     = bus.in_enq__ENA & bus.in_enq__RDY;

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        step     = 1'b0;
        store    = 1'b0;
        err_set  = 1'b0;
        say_ena  = 1'b0;
        say2_ena = 1'b0;
        case (state_q)
            HDR: if (acc) begin
                if (hdr_ok) begin
                    load    = 1'b1;
                    state_d = ARG;
                end else begin
                    err_set = 1'b1;
                    // A zero-length bad header has no payload to skip.
                    if (hdr_len != '0) begin
                        load    = 1'b1;
                        state_d = DROP;
                    end
                end
            end
            ARG: if (acc) begin
                step  = 1'b1;
                store = 1'b1;
                if (last) state_d = ISSUE;
            end
            DROP: if (acc) begin
                step = 1'b1;
                if (last) state_d = HDR;
            end
            ISSUE: begin
                say_ena  = !is_say2_q && bus.say__RDY;
                say2_ena = is_say2_q && bus.say2__RDY;
                if (say_ena || say2_ena) state_d = HDR;
            end
            default: state_d = HDR;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= HDR;
            is_say2_q   <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            err_pulse_q <= err_set;
            if (load) is_say2_q <= (hdr_id == ECHO_SAY2);
            if (err_set && (err_count_q != '1))
                err_count_q <= err_count_q + ERR_CNT_WIDTH'(1);
        end
    end

    echo_arg_collector #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (HDR_LEN_W)
    ) u_collector (
        .CLK      (CLK),
        .nRST     (nRST),
        .load     (load),
        .load_len (hdr_len),
        .step     (step),
        .store    (store),
        .word     (bus.in_enq_v),
        .last     (last),
        .arg_a    (arg_a),
        .arg_b    (arg_b)
    );

    // Gated by reset so the host sees no ready while the decoder is held.
    assign bus.in_enq__RDY = nRST && (state_q != ISSUE);
    assign bus.say__ENA    = say_ena;
    assign bus.say_v       = arg_a;
    assign bus.say2__ENA   = say2_ena;
    assign bus.say2_a      = arg_a;
    assign bus.say2_b      = arg_b;
    assign bus.err_pulse   = err_pulse_q;
    assign bus.err_count   = err_count_q;

`ifdef ECHO_DECODE_TRACE_EN
    always @(posedge CLK) begin
        if (say_ena)  $display("echo_decode: say v=%0d", arg_a);
        if (say2_ena) $display("echo_decode: say2 a=%0d b=%0d", arg_a, arg_b);
        if (err_set)  $display("echo_decode: rejected header id=%0d len=%0d", hdr_id, hdr_len);
    end
`endif

endmodule

// File: tb/tb_echo_request_decoder.sv
// Directed vector bench for echo_request_decoder: per-cycle table plus reset,
// saturation and mid-message reset sequences.
module tb_echo_request_decoder;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    always #5 CLK = ~CLK;

    echo_request_decoder_if #(.DATA_WIDTH(32), .ERR_CNT_WIDTH(8)) bus ();

    echo_request_decoder #(.DATA_WIDTH(32), .ERR_CNT_WIDTH(8)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    typedef struct {
        logic        ena;
        logic [31:0] v;
        logic        sr;
        logic        s2r;
        logic        rdy;
        logic        se;
        logic [31:0] sv;
        logic        s2e;
        logic [31:0] a;
        logic [31:0] b;
        logic        ep;
        logic [7:0]  ec;
    } vec_t;

    localparam int NVEC = 33;
    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic ena, input logic [31:0] v, input logic sr,
                                input logic s2r, input logic rdy, input logic se,
                                input logic [31:0] sv, input logic s2e, input logic [31:0] a,
                                input logic [31:0] b, input logic ep, input logic [7:0] ec);
        vec_t t;
        t.ena = ena; t.v = v; t.sr = sr; t.s2r = s2r; t.rdy = rdy; t.se = se;
        t.sv = sv; t.s2e = s2e; t.a = a; t.b = b; t.ep = ep; t.ec = ec;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ena, input logic [31:0] v, input logic sr, input logic s2r);
        bus.in_enq__ENA = ena;
        bus.in_enq_v    = v;
        bus.say__RDY    = sr;
        bus.say2__RDY   = s2r;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " rdy"},   32'(bus.in_enq__RDY), 32'd0);
        chk({tag, " se"},    32'(bus.say__ENA),    32'd0);
        chk({tag, " s2e"},   32'(bus.say2__ENA),   32'd0);
        chk({tag, " sv"},    bus.say_v,            32'd0);
        chk({tag, " a"},     bus.say2_a,           32'd0);
        chk({tag, " b"},     bus.say2_b,           32'd0);
        chk({tag, " ep"},    32'(bus.err_pulse),   32'd0);
        chk({tag, " ec"},    32'(bus.err_count),   32'd0);
    endtask

    task automatic do_reset();
        drive(1'b0, 32'd0, 1'b1, 1'b1);
        nRST = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        chk_all_zero("reset");
        nRST = 1'b1;
        #1;
        chk("reset release rdy", 32'(bus.in_enq__RDY), 32'd1);
    endtask

    initial begin
        drive(1'b0, 32'd0, 1'b0, 1'b0);

        //            ena  v             sr s2r  rdy se sv     s2e a     b     ep ec
        tbl[0]  = mk(1, 32'h00000001, 1, 1,   1, 0, 0,     0, 0,    0,    0, 0);
        tbl[1]  = mk(1, 32'd22,       1, 1,   1, 0, 0,     0, 0,    0,    0, 0);
        tbl[2]  = mk(0, 32'd0,        1, 1,   0, 1, 22,    0, 0,    0,    0, 0);
        tbl[3]  = mk(0, 32'd0,        1, 1,   1, 0, 0,     0, 0,    0,    0, 0);
        tbl[4]  = mk(1, 32'h00010002, 1, 1,   1, 0, 0,     0, 0,    0,    0, 0);
        tbl[5]  = mk(1, 32'd5,        1, 1,   1, 0, 0,     0, 0,    0,    0, 0);
        tbl[6]  = mk(1, 32'd7,        1, 1,   1, 0, 0,     0, 0,    0,    0, 0);
        tbl[7]  = mk(0, 32'd0,        1, 1,   0, 0, 0,     1, 5,    7,    0, 0);
        tbl[8]  = mk(0, 32'd0,        1, 1,   1, 0, 0,     0, 0,    0,    0, 0);
        tbl[9]  = mk(1, 32'h00070003, 1, 1,   1, 0, 0,     0, 0,    0,    0, 0);
        tbl[10] = mk(1, 32'd1,        1, 1,   1, 0, 0,     0, 0,    0,    1, 1);
        tbl[11] = mk(1, 32'd2,        1, 1,   1, 0, 0,     0, 0,    0,    0, 1);
        tbl[12] = mk(1, 32'd3,        1, 1,   1, 0, 0,     0, 0,    0,    0, 1);
        tbl[13] = mk(1, 32'h00000001, 1, 1,   1, 0, 0,     0, 0,    0,    0, 1);
        tbl[14] = mk(1, 32'd9,        1, 1,   1, 0, 0,     0, 0,    0,    0, 1);
        tbl[15] = mk(0, 32'd0,        1, 1,   0, 1, 9,     0, 0,    0,    0, 1);
        tbl[16] = mk(0, 32'd0,        1, 1,   1, 0, 0,     0, 0,    0,    0, 1);
        tbl[17] = mk(1, 32'h00000002, 1, 1,   1, 0, 0,     0, 0,    0,    0, 1);
        tbl[18] = mk(1, 32'h0000AAAA, 1, 1,   1, 0, 0,     0, 0,    0,    1, 2);
        tbl[19] = mk(1, 32'h0000BBBB, 1, 1,   1, 0, 0,     0, 0,    0,    0, 2);
        tbl[20] = mk(0, 32'd0,        1, 1,   1, 0, 0,     0, 0,    0,    0, 2);
        tbl[21] = mk(1, 32'h00000001, 0, 1,   1, 0, 0,     0, 0,    0,    0, 2);
        tbl[22] = mk(1, 32'd22,       0, 1,   1, 0, 0,     0, 0,    0,    0, 2);
        tbl[23] = mk(0, 32'd0,        0, 1,   0, 0, 0,     0, 0,    0,    0, 2);
        tbl[24] = mk(0, 32'd0,        0, 1,   0, 0, 0,     0, 0,    0,    0, 2);
        tbl[25] = mk(0, 32'd0,        0, 1,   0, 0, 0,     0, 0,    0,    0, 2);
        tbl[26] = mk(0, 32'd0,        1, 1,   0, 1, 22,    0, 0,    0,    0, 2);
        tbl[27] = mk(1, 32'h00010002, 1, 1,   1, 0, 0,     0, 0,    0,    0, 2);
        tbl[28] = mk(1, 32'd5,        1, 1,   1, 0, 0,     0, 0,    0,    0, 2);
        tbl[29] = mk(1, 32'd7,        1, 1,   1, 0, 0,     0, 0,    0,    0, 2);
        tbl[30] = mk(0, 32'd0,        1, 0,   0, 0, 0,     0, 0,    0,    0, 2);
        tbl[31] = mk(0, 32'd0,        1, 1,   0, 0, 0,     1, 5,    7,    0, 2);
        tbl[32] = mk(0, 32'd0,        1, 1,   1, 0, 0,     0, 0,    0,    0, 2);

        do_reset();

        for (int i = 0; i < NVEC; i++) begin
            @(negedge CLK);
            drive(tbl[i].ena, tbl[i].v, tbl[i].sr, tbl[i].s2r);
            #1;
            chk($sformatf("vec%0d rdy", i), 32'(bus.in_enq__RDY), 32'(tbl[i].rdy));
            chk($sformatf("vec%0d se", i),  32'(bus.say__ENA),    32'(tbl[i].se));
            chk($sformatf("vec%0d s2e", i), 32'(bus.say2__ENA),   32'(tbl[i].s2e));
            chk($sformatf("vec%0d ep", i),  32'(bus.err_pulse),   32'(tbl[i].ep));
            chk($sformatf("vec%0d ec", i),  32'(bus.err_count),   32'(tbl[i].ec));
            if (tbl[i].se) chk($sformatf("vec%0d say_v", i), bus.say_v, tbl[i].sv);
            if (tbl[i].s2e) begin
                chk($sformatf("vec%0d say2_a", i), bus.say2_a, tbl[i].a);
                chk($sformatf("vec%0d say2_b", i), bus.say2_b, tbl[i].b);
            end
        end

        // Zero-length headers: counter saturates, decoder never leaves HDR.
        do_reset();
        for (int k = 0; k < 256; k++) begin
            @(negedge CLK);
            drive(1'b1, 32'h00000000, 1'b1, 1'b1);
            #1;
            chk($sformatf("sat%0d rdy", k), 32'(bus.in_enq__RDY), 32'd1);
            chk($sformatf("sat%0d se", k),  32'(bus.say__ENA),    32'd0);
            chk($sformatf("sat%0d s2e", k), 32'(bus.say2__ENA),   32'd0);
            chk($sformatf("sat%0d ec", k),  32'(bus.err_count),   32'(k));
            chk($sformatf("sat%0d ep", k),  32'(bus.err_pulse),   32'(k > 0));
        end
        @(negedge CLK);
        drive(1'b0, 32'd0, 1'b1, 1'b1);
        #1;
        chk("sat final ec", 32'(bus.err_count), 32'd255);
        chk("sat final ep", 32'(bus.err_pulse), 32'd1);
        chk("sat final rdy", 32'(bus.in_enq__RDY), 32'd1);
        @(negedge CLK);
        #1;
        chk("sat idle ep", 32'(bus.err_pulse), 32'd0);
        chk("sat idle ec", 32'(bus.err_count), 32'd255);

        // Asynchronous reset in the middle of a say2 message.
        @(negedge CLK);
        drive(1'b1, 32'h00010002, 1'b1, 1'b1);
        @(negedge CLK);
        drive(1'b1, 32'd5, 1'b1, 1'b1);
        @(negedge CLK);
        drive(1'b0, 32'd0, 1'b1, 1'b1);
        #1;
        chk("pre-reset say2_a", bus.say2_a, 32'd5);
        chk("pre-reset rdy", 32'(bus.in_enq__RDY), 32'd1);
        nRST = 1'b0;
        #1;
        chk_all_zero("async reset");
        @(negedge CLK);
        #1;
        chk_all_zero("held reset");
        nRST = 1'b1;
        @(negedge CLK);
        drive(1'b1, 32'h00000001, 1'b1, 1'b1);
        #1;
        chk("post-reset hdr rdy", 32'(bus.in_enq__RDY), 32'd1);
        chk("post-reset hdr s2e", 32'(bus.say2__ENA), 32'd0);
        @(negedge CLK);
        drive(1'b1, 32'd4, 1'b1, 1'b1);
        #1;
        chk("post-reset arg s2e", 32'(bus.say2__ENA), 32'd0);
        @(negedge CLK);
        drive(1'b0, 32'd0, 1'b1, 1'b1);
        #1;
        chk("post-reset se", 32'(bus.say__ENA), 32'd1);
        chk("post-reset say_v", bus.say_v, 32'd4);
        chk("post-reset s2e", 32'(bus.say2__ENA), 32'd0);
        chk("post-reset ec", 32'(bus.err_count), 32'd0);
        @(negedge CLK);
        #1;
        chk("post-reset idle se", 32'(bus.say__ENA), 32'd0);
        chk("post-reset idle rdy", 32'(bus.in_enq__RDY), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
